wb_mem_arbiter: RTL and testbench

//  Two-master, one-slave Wishbone (pipelined) arbiter in front of the combined main_memory.
//  M0 = instruction fetch, M1 = load/store unit. Grants the slave to one master for a whole
//  bus cycle (cyc high), round-robin on contention, with an ack watchdog that errors a hung cycle.

---
 rtl/wb_mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_wb_mem_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_arbiter.sv
// Two-master, one-slave pipelined Wishbone arbiter: whole-cycle grants, round-robin on
// contention, and an ack watchdog that errors and parks a hung bus cycle.
module wb_mem_arbiter #(
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_m0_wb_cyc,
  input  logic                  i_m0_wb_stb,
  input  logic                  i_m0_wb_we,
  input  logic [ADDR_WIDTH-1:0] i_m0_wb_addr,
  input  logic [31:0]           i_m0_wb_data,
  input  logic [3:0]            i_m0_wb_sel,
  output logic                  o_m0_wb_ack,
  output logic                  o_m0_wb_stall,
  output logic                  o_m0_wb_err,
  output logic [31:0]           o_m0_wb_data,
  input  logic                  i_m1_wb_cyc,
  input  logic                  i_m1_wb_stb,
  input  logic                  i_m1_wb_we,
  input  logic [ADDR_WIDTH-1:0] i_m1_wb_addr,
  input  logic [31:0]           i_m1_wb_data,
  input  logic [3:0]            i_m1_wb_sel,
  output logic                  o_m1_wb_ack,
  output logic                  o_m1_wb_stall,
  output logic                  o_m1_wb_err,
  output logic [31:0]           o_m1_wb_data,
  output logic                  o_s_wb_cyc,
  output logic                  o_s_wb_stb,
  output logic                  o_s_wb_we,
  output logic [ADDR_WIDTH-1:0] o_s_wb_addr,
  output logic [31:0]           o_s_wb_data,
  output logic [3:0]            o_s_wb_sel,
  input  logic                  i_s_wb_ack,
  input  logic                  i_s_wb_stall,
  input  logic [31:0]           i_s_wb_data,
  output logic [1:0]            o_grant
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  logic [1:0]    state, state_nxt, arb;
  logic          last_grant, last_nxt;  // 0 = M0, 1 = M1; also names the faulted master in ERR
  logic [CW-1:0] cnt, cnt_nxt;
  logic          granted, own_cyc, timeout, take_arb;

  assign granted = (state == GNT0) || (state == GNT1);
  assign own_cyc = (state == GNT0) ? i_m0_wb_cyc :
                   (state == GNT1) ? i_m1_wb_cyc : 1'b0;
  // An ack in the same cycle rescues the transfer, so it takes priority over the timeout.
  assign timeout = (TIMEOUT_CYCLES != 0) && granted && own_cyc && !i_s_wb_ack && (cnt == CNT_MAX);
  assign take_arb = (state == IDLE) || (granted && !own_cyc);

  always_comb begin
    if (i_m0_wb_cyc && i_m1_wb_cyc) arb = last_grant ? GNT0 : GNT1;
    else if (i_m0_wb_cyc)           arb = GNT0;
    else if (i_m1_wb_cyc)           arb = GNT1;
    else                            arb = IDLE;
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last_grant;
    cnt_nxt   = cnt;
    if (take_arb) begin
      state_nxt = arb;
      if (arb != IDLE) begin
        last_nxt = (arb == GNT1);
        cnt_nxt  = '0;
      end
    end else if (granted) begin
      if (timeout)               state_nxt = ERR;
      else if (i_s_wb_ack)       cnt_nxt   = '0;
      else if (cnt != CNT_MAX)   cnt_nxt   = cnt + CW'(1);
    end else if (state == ERR) begin
      if (!(last_grant ? i_m1_wb_cyc : i_m0_wb_cyc)) state_nxt = IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_nxt;
      cnt        <= cnt_nxt;
    end
  end

  // Routing depends only on registered state, so async reset idles the bus with no edge.
  always_comb begin
    o_s_wb_cyc    = 1'b0;
    o_s_wb_stb    = 1'b0;
    o_s_wb_we     = 1'b0;
    o_s_wb_addr   = '0;
    o_s_wb_data   = '0;
    o_s_wb_sel    = '0;
    o_m0_wb_ack   = 1'b0;
    o_m0_wb_stall = 1'b1;
    o_m0_wb_err   = 1'b0;
    o_m0_wb_data  = '0;
    o_m1_wb_ack   = 1'b0;
    o_m1_wb_stall = 1'b1;
    o_m1_wb_err   = 1'b0;
    o_m1_wb_data  = '0;
    case (state)
      GNT0: begin
        o_s_wb_cyc    = i_m0_wb_cyc;
        o_s_wb_stb    = i_m0_wb_stb;
        o_s_wb_we     = i_m0_wb_we;
        o_s_wb_addr   = i_m0_wb_addr;
        o_s_wb_data   = i_m0_wb_data;
        o_s_wb_sel    = i_m0_wb_sel;
        o_m0_wb_stall = i_s_wb_stall;
        o_m0_wb_ack   = i_s_wb_ack;
        o_m0_wb_data  = i_s_wb_data;
        o_m0_wb_err   = timeout;
      end
      GNT1: begin
        o_s_wb_cyc    = i_m1_wb_cyc;
        o_s_wb_stb    = i_m1_wb_stb;
        o_s_wb_we     = i_m1_wb_we;
        o_s_wb_addr   = i_m1_wb_addr;
        o_s_wb_data   = i_m1_wb_data;
        o_s_wb_sel    = i_m1_wb_sel;
        o_m1_wb_stall = i_s_wb_stall;
        o_m1_wb_ack   = i_s_wb_ack;
        o_m1_wb_data  = i_s_wb_data;
        o_m1_wb_err   = timeout;
      end
      default: ;
    endcase
  end

  assign o_grant = {state == GNT1, state == GNT0};

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Randomized bench for wb_mem_arbiter: stimulus pushes expected outputs from a bus-ownership
// model into a queue; a negedge monitor pops and compares against the DUT.
module tb_wb_mem_arbiter;
  localparam int AW = 10;
  localparam int TO = 4;

  typedef struct packed {
    logic cyc, stb, we;
    logic [AW-1:0] addr;
    logic [31:0] data;
    logic [3:0] sel;
  } mreq_t;

  typedef struct packed {
    logic [1:0] grant;
    logic s_cyc, s_stb, s_we;
    logic [AW-1:0] s_addr;
    logic [31:0] s_data;
    logic [3:0] s_sel;
    logic ack0, ack1, err0, err1, stall0, stall1;
    logic [31:0] d0, d1;
  } exp_t;

  logic i_clk = 1'b0, i_rst_n = 1'b0;
  logic m0_cyc = 0, m0_stb = 0, m0_we = 0, m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_data = '0, m1_data = '0, s_rdata = '0;
  logic [3:0] m0_sel = '0, m1_sel = '0;
  logic s_ack = 0, s_stall = 0;
  logic m0_ack, m0_stall, m0_err, m1_ack, m1_stall, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic s_cyc, s_stb, s_we;
  logic [AW-1:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0] s_sel;
  logic [1:0] grant;

  wb_mem_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_m0_wb_cyc(m0_cyc), .i_m0_wb_stb(m0_stb), .i_m0_wb_we(m0_we),
    .i_m0_wb_addr(m0_addr), .i_m0_wb_data(m0_data), .i_m0_wb_sel(m0_sel),
    .o_m0_wb_ack(m0_ack), .o_m0_wb_stall(m0_stall), .o_m0_wb_err(m0_err), .o_m0_wb_data(m0_rdata),
    .i_m1_wb_cyc(m1_cyc), .i_m1_wb_stb(m1_stb), .i_m1_wb_we(m1_we),
    .i_m1_wb_addr(m1_addr), .i_m1_wb_data(m1_data), .i_m1_wb_sel(m1_sel),
    .o_m1_wb_ack(m1_ack), .o_m1_wb_stall(m1_stall), .o_m1_wb_err(m1_err), .o_m1_wb_data(m1_rdata),
    .o_s_wb_cyc(s_cyc), .o_s_wb_stb(s_stb), .o_s_wb_we(s_we),
    .o_s_wb_addr(s_addr), .o_s_wb_data(s_wdata), .o_s_wb_sel(s_sel),
    .i_s_wb_ack(s_ack), .i_s_wb_stall(s_stall), .i_s_wb_data(s_rdata),
    .o_grant(grant)
  );

  always #5 i_clk = ~i_clk;

  exp_t sb[$];
  int n_chk = 0, n_fail = 0;

  // Ownership model: -1 nobody, 0/1 that master owns the bus, 2 parked after a timeout.
  int owner = -1, last = 1, cnt = 0, faulted = 0;

  function automatic mreq_t mk(logic c, logic s, logic w, logic [AW-1:0] a, logic [31:0] d, logic [3:0] sl);
    mreq_t r;
    r.cyc = c; r.stb = s; r.we = w; r.addr = a; r.data = d; r.sel = sl;
    return r;
  endfunction

  task automatic give_bus(input logic c0, input logic c1);
    int w;
    w = (c0 && c1) ? 1 - last : c0 ? 0 : c1 ? 1 : -1;
    owner = w;
    if (w >= 0) begin
      last = w;
      cnt  = 0;
    end
  endtask

  task automatic step(input mreq_t r0, input mreq_t r1, input logic ack, input logic stall,
                      input logic [31:0] sd, input logic rst_lvl);
    exp_t e;
    mreq_t own;
    logic expired;
    @(posedge i_clk);
    #1;
    {m0_cyc, m0_stb, m0_we, m0_addr, m0_data, m0_sel} = r0;
    {m1_cyc, m1_stb, m1_we, m1_addr, m1_data, m1_sel} = r1;
    s_ack = ack; s_stall = stall; s_rdata = sd;
    if (rst_lvl) i_rst_n = 1'b1;
    else begin
      #1;
      i_rst_n = 1'b0;
    end
    own = (owner == 1) ? r1 : r0;
    expired = (owner == 0 || owner == 1) && own.cyc && !ack && cnt == TO;
    e = '0;
    e.stall0 = 1'b1;
    e.stall1 = 1'b1;
    if (rst_lvl && (owner == 0 || owner == 1)) begin
      e.grant = (owner == 0) ? 2'b01 : 2'b10;
      e.s_cyc = own.cyc; e.s_stb = own.stb; e.s_we = own.we;
      e.s_addr = own.addr; e.s_data = own.data; e.s_sel = own.sel;
      if (owner == 0) begin
        e.stall0 = stall; e.ack0 = ack; e.d0 = sd; e.err0 = expired;
      end else begin
        e.stall1 = stall; e.ack1 = ack; e.d1 = sd; e.err1 = expired;
      end
    end
    sb.push_back(e);
    if (!rst_lvl) begin
      owner = -1; last = 1; cnt = 0;
    end else if (owner == -1) begin
      give_bus(r0.cyc, r1.cyc);
    end else if (owner == 2) begin
      if (!(faulted == 1 ? r1.cyc : r0.cyc)) owner = -1;
    end else if (!own.cyc) begin
      give_bus(r0.cyc, r1.cyc);
    end else if (expired) begin
      faulted = owner;
      owner = 2;
    end else if (ack) cnt = 0;
    else if (cnt < TO) cnt = cnt + 1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("grant", 32'(grant), 32'(e.grant));
        chk("s_cyc", 32'(s_cyc), 32'(e.s_cyc));
        chk("s_stb", 32'(s_stb), 32'(e.s_stb));
        chk("s_we", 32'(s_we), 32'(e.s_we));
        chk("s_addr", 32'(s_addr), 32'(e.s_addr));
        chk("s_data", s_wdata, e.s_data);
        chk("s_sel", 32'(s_sel), 32'(e.s_sel));
        chk("m0_ack", 32'(m0_ack), 32'(e.ack0));
        chk("m1_ack", 32'(m1_ack), 32'(e.ack1));
        chk("m0_err", 32'(m0_err), 32'(e.err0));
        chk("m1_err", 32'(m1_err), 32'(e.err1));
        chk("m0_stall", 32'(m0_stall), 32'(e.stall0));
        chk("m1_stall", 32'(m1_stall), 32'(e.stall1));
        chk("m0_data", m0_rdata, e.d0);
        chk("m1_data", m1_rdata, e.d1);
      end
    end
  end

  initial begin : stim
    mreq_t nil, r0, r1, w1, c0, c1;
    nil = '0;
    step(nil, nil, 0, 0, 0, 0);
    step(nil, nil, 1, 0, 32'h1111, 0);
    // single M0 read of 0x010
    r0 = mk(1, 1, 0, 10'h010, 32'h0, 4'hf);
    step(r0, nil, 0, 0, 0, 1);
    step(r0, nil, 1, 0, 32'hDEADBEEF, 1);
    step(nil, nil, 0, 0, 0, 1);
    // contention right after reset: M0 first, then strict alternation
    step(nil, nil, 0, 0, 0, 0);
    c0 = mk(1, 1, 0, 10'h020, 32'h0, 4'hf);
    c1 = mk(1, 1, 1, 10'h030, 32'h1234, 4'h1);
    step(c0, c1, 0, 0, 0, 1);
    step(c0, c1, 1, 0, 32'hA0, 1);
    step(nil, c1, 0, 0, 0, 1);
    step(c0, c1, 1, 0, 32'hA1, 1);
    step(c0, nil, 0, 0, 0, 1);
    step(c0, c1, 1, 0, 32'hA2, 1);
    step(nil, nil, 0, 0, 0, 1);
    step(nil, nil, 0, 0, 0, 1);
    // M1 write holds the bus while M0 waits
    w1 = mk(1, 1, 1, 10'h040, 32'h0000ABCD, 4'b0011);
    step(nil, w1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(r0, w1, 0, 0, 0, 1);
    step(r0, w1, 1, 0, 0, 1);
    step(r0, nil, 0, 0, 0, 1);
    step(r0, nil, 1, 0, 32'h55, 1);
    step(nil, nil, 0, 0, 0, 1);
    // watchdog: slave never acks M0
    for (int i = 0; i < 8; i++) step(r0, nil, 0, 0, 0, 1);
    r1 = mk(1, 1, 0, 10'h3FF, 32'h0, 4'hf);
    for (int i = 0; i < 3; i++) step(nil, r1, 0, 0, 0, 1);
    step(nil, r1, 1, 0, 32'h77, 1);
    step(nil, nil, 0, 0, 0, 1);
    // slave stall mirrored to M0 with address held
    step(r0, nil, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(r0, nil, 0, 1, 0, 1);
    step(r0, nil, 1, 0, 32'h99, 1);
    step(nil, nil, 0, 0, 0, 1);
    // reset in the middle of an M1 read
    step(nil, r1, 0, 0, 0, 1);
    step(nil, r1, 0, 0, 0, 1);
    step(nil, r1, 1, 0, 32'hBAD, 0);
    step(nil, nil, 0, 0, 0, 1);
    // random traffic
    r0 = nil; r1 = nil;
    for (int i = 0; i < 3000; i++) begin
      if (r0.cyc) r0.cyc = ($urandom_range(4) != 0);
      else        r0.cyc = ($urandom_range(2) == 0);
      if (r1.cyc) r1.cyc = ($urandom_range(4) != 0);
      else        r1.cyc = ($urandom_range(2) == 0);
      r0.stb = 1'($urandom); r0.we = 1'($urandom); r0.addr = AW'($urandom);
      r0.data = $urandom; r0.sel = 4'($urandom);
      r1.stb = 1'($urandom); r1.we = 1'($urandom); r1.addr = AW'($urandom);
      r1.data = $urandom; r1.sel = 4'($urandom);
      step(r0, r1, 1'($urandom), ($urandom_range(3) == 0), $urandom, ($urandom_range(199) != 0));
    end
    @(posedge i_clk);
    @(negedge i_clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
